// File: rtl/str_ring_controller_pkg.sv
// Shared types and default constants for the self-timed ring controller and its tap monitor.
package str_ring_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SETTLE,
    GATE,
    REPORT
  } state_e;

  localparam int unsigned N_STAGES_DEF      = 30;
  localparam logic [29:0] INIT_PATTERN_DEF  = 30'h0000_7FFF;
  localparam int unsigned INIT_CYCLES_DEF   = 4;
  localparam int unsigned SETTLE_CYCLES_DEF = 64;
  localparam int unsigned CNT_W_DEF         = 16;
  localparam int unsigned STALL_CYCLES_DEF  = 256;
  localparam int unsigned GATE_W            = 16;

endpackage

// File: rtl/str_ring_controller_tap_sync.sv
// Brings the asynchronous ring tap into clk and emits a one-cycle pulse per transition (3-cycle latency).
module str_ring_controller_tap_sync (
  input  logic clk,
  input  logic rst,
  input  logic tap_in,
  output logic edge_pulse
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic edge_q, edge_d;

  always_comb begin
    s1_d   = tap_in;
    s2_d   = s1_q;
    s3_d   = s2_q;
    edge_d = s2_q ^ s3_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      edge_q <= edge_d;
    end
  end

  assign edge_pulse = edge_q;

endmodule

// File: rtl/str_ring_controller.sv
// Hold/release sequencer and gated edge counter for the 30-stage INV/NOR self-timed ring.
// Idle-tap stall detection is built in when STR_STALL_DETECT_EN is defined.
module str_ring_controller
  import str_ring_controller_pkg::*;
#(
  parameter int unsigned         N_STAGES      = N_STAGES_DEF,
  parameter logic [N_STAGES-1:0] INIT_PATTERN  = N_STAGES'(INIT_PATTERN_DEF),
  parameter int unsigned         INIT_CYCLES   = INIT_CYCLES_DEF,
  parameter int unsigned         SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned         CNT_W         = CNT_W_DEF,
  parameter int unsigned         STALL_CYCLES  = STALL_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [15:0]         cfg_gate,
  input  logic                tap_in,
  output logic                ring_init_en,
  output logic [N_STAGES-1:0] ring_init_val,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    count,
  output logic                count_valid,
  output logic                overflow,
  output logic                stall
);

  localparam int unsigned PH_W    = GATE_W;
  localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);

`ifdef STR_STALL_DETECT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [PH_W-1:0]    gate_len_q, gate_len_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic [STALL_W-1:0] idle_q, idle_d;
  logic               ring_init_en_q, ring_init_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               count_valid_q, count_valid_d;
  logic               overflow_q, overflow_d;
  logic               stall_q, stall_d;
  logic               edge_pulse;
  logic               stall_hit;

  str_ring_controller_tap_sync u_tap_sync (
    .clk        (clk),
    .rst        (rst),
    .tap_in     (tap_in),
    .edge_pulse (edge_pulse)
  );

  // Cycles since the last tap edge while the ring is free-running; folds away when stall detect is off.
  always_comb begin
    idle_d    = '0;
    stall_hit = 1'b0;
    if (STALL_EN && (state_q == SETTLE || state_q == GATE) && !edge_pulse) begin
      idle_d    = idle_q + STALL_W'(1);
      stall_hit = (idle_q == STALL_W'(STALL_CYCLES - 1));
    end
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    gate_len_d    = gate_len_q;
    edge_cnt_d    = edge_cnt_q;
    ovf_acc_d     = ovf_acc_q;
    count_d       = count_q;
    count_valid_d = count_valid_q;
    overflow_d    = overflow_q;
    stall_d       = stall_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d       = INIT;
          phase_d       = '0;
          gate_len_d    = (cfg_gate == 16'd0) ? PH_W'(1) : cfg_gate;
          edge_cnt_d    = '0;
          ovf_acc_d     = 1'b0;
          count_d       = '0;
          count_valid_d = 1'b0;
          overflow_d    = 1'b0;
          stall_d       = 1'b0;
        end
      end
      INIT: begin
        if (phase_q == PH_W'(INIT_CYCLES - 1)) begin
          state_d = SETTLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      SETTLE: begin
        if (stall_hit) begin
          state_d = REPORT;
        end else if (phase_q == PH_W'(SETTLE_CYCLES - 1)) begin
          state_d    = GATE;
          phase_d    = '0;
          edge_cnt_d = '0;
          ovf_acc_d  = 1'b0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      GATE: begin
        // Saturate rather than wrap; overflow records that real edges were lost.
        if (edge_pulse) begin
          if (edge_cnt_q == '1) ovf_acc_d = 1'b1;
          else                  edge_cnt_d = edge_cnt_q + CNT_W'(1);
        end
        if (stall_hit || phase_q == gate_len_q - PH_W'(1)) state_d = REPORT;
        else                                              phase_d = phase_q + PH_W'(1);
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort) state_d = IDLE;

    if (state_d == REPORT) begin
      count_d       = edge_cnt_d;
      overflow_d    = ovf_acc_d;
      stall_d       = stall_hit;
      count_valid_d = 1'b1;
    end

    done_d         = (state_d == REPORT);
    busy_d         = (state_d != IDLE);
    ring_init_en_d = (state_d == IDLE) || (state_d == INIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      phase_q        <= '0;
      gate_len_q     <= PH_W'(1);
      edge_cnt_q     <= '0;
      ovf_acc_q      <= 1'b0;
      idle_q         <= '0;
      ring_init_en_q <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      count_q        <= '0;
      count_valid_q  <= 1'b0;
      overflow_q     <= 1'b0;
      stall_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      gate_len_q     <= gate_len_d;
      edge_cnt_q     <= edge_cnt_d;
      ovf_acc_q      <= ovf_acc_d;
      idle_q         <= idle_d;
      ring_init_en_q <= ring_init_en_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      count_q        <= count_d;
      count_valid_q  <= count_valid_d;
      overflow_q     <= overflow_d;
      stall_q        <= stall_d;
    end
  end

  assign ring_init_en  = ring_init_en_q;
  assign ring_init_val = INIT_PATTERN;
  assign busy          = busy_q;
  assign done          = done_q;
  assign count         = count_q;
  assign count_valid   = count_valid_q;
  assign overflow      = overflow_q;
  assign stall         = stall_q;

endmodule

// File: tb/tb_str_ring_controller.sv
// Bench for str_ring_controller: a default instance and a small one (CNT_W=4, STALL_CYCLES=32) share stimulus.
module tb_str_ring_controller;

  localparam int INIT_C   = 4;
  localparam int SETTLE_C = 64;
  localparam int MAXC     = 16384;
  localparam int STALL_A  = 256;
  localparam int STALL_B  = 32;
  localparam int CMAX_A   = 65535;
  localparam int CMAX_B   = 15;
`ifdef STR_STALL_DETECT_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        tap_in = 1'b0;
  logic [15:0] cfg_gate = 16'd0;

  logic        rie_a, rie_b, busy_a, busy_b, done_a, done_b;
  logic        cv_a, cv_b, ovf_a, ovf_b, stall_a, stall_b;
  logic [29:0] riv_a, riv_b;
  logic [15:0] count_a;
  logic [3:0]  count_b;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int done_n [2];
  int done_at [2];
  bit tap_arr [MAXC];
  int tmode = 0;
  int tper = 4;
  int tprob = 20;

  str_ring_controller u_dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_gate(cfg_gate), .tap_in(tap_in),
    .ring_init_en(rie_a), .ring_init_val(riv_a), .busy(busy_a), .done(done_a), .count(count_a),
    .count_valid(cv_a), .overflow(ovf_a), .stall(stall_a)
  );

  str_ring_controller #(.CNT_W(4), .STALL_CYCLES(STALL_B)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_gate(cfg_gate), .tap_in(tap_in),
    .ring_init_en(rie_b), .ring_init_val(riv_b), .busy(busy_b), .done(done_b), .count(count_b),
    .count_valid(cv_b), .overflow(ovf_b), .stall(stall_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done_a) begin done_n[0] <= done_n[0] + 1; done_at[0] <= cyc; end
    if (done_b) begin done_n[1] <= done_n[1] + 1; done_at[1] <= cyc; end
  end

  // Tap driver; tap_arr[k] is the value sampled at posedge number k.
  initial begin
    logic v;
    forever begin
      @(negedge clk);
      case (tmode)
        1:       v = (((cyc + 1) / tper) % 2) != 0;
        2:       v = ($urandom_range(0, 99) < tprob) ? ~tap_in : tap_in;
        default: v = tap_in;
      endcase
      tap_in = v;
      if (cyc + 1 < MAXC) tap_arr[cyc + 1] = v;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: start sampled at posedge s; ring free from posedge s+INIT_C, gate covers g cycles after settle.
  // An edge seen by the controller in cycle k reflects a tap change between samples k-3 and k-2.
  function automatic void model(input int s, input int g, input int cmax, input int stall_lim,
                                output int rep_at, output int cnt, output bit ovf, output bit stl);
    int run = 0;
    int raw = 0;
    bit e;
    rep_at = s + INIT_C + SETTLE_C + g;
    stl    = 1'b0;
    for (int k = s + INIT_C; k < s + INIT_C + SETTLE_C + g; k++) begin
      e = tap_arr[k - 2] != tap_arr[k - 3];
      if (e && k >= s + INIT_C + SETTLE_C) raw++;
      run = e ? 0 : run + 1;
      if (STALL_ON && run == stall_lim) begin
        rep_at = k + 1;
        stl    = 1'b1;
        break;
      end
    end
    cnt = (raw > cmax) ? cmax : raw;
    ovf = raw > cmax;
  endfunction

  task automatic run_meas(input string name, input int gate, input bit mid_start);
    int s, g, base_a, base_b, ra, rb, ca, cb;
    bit oa, ob, sa, sb;
    g = (gate == 0) ? 1 : gate;
    @(negedge clk);
    cfg_gate = 16'(gate);
    start    = 1'b1;
    s        = cyc + 1;
    base_a   = done_n[0];
    base_b   = done_n[1];
    @(negedge clk);
    start    = 1'b0;
    cfg_gate = 16'($urandom);
    chk({name, ".cv_clr_a"}, cv_a, 0);
    chk({name, ".ovf_clr_a"}, ovf_a, 0);
    chk({name, ".ovf_clr_b"}, ovf_b, 0);
    chk({name, ".busy_a"}, busy_a, 1);
    while (cyc < s + INIT_C - 1) @(negedge clk);
    chk({name, ".held_a"}, rie_a, 1);
    @(negedge clk);
    chk({name, ".release_a"}, rie_a, 0);
    chk({name, ".release_b"}, rie_b, 0);
    if (mid_start) begin
      while (cyc < s + 20) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    while (cyc < s + INIT_C + SETTLE_C + g + 3) @(negedge clk);
    model(s, g, CMAX_A, STALL_A, ra, ca, oa, sa);
    model(s, g, CMAX_B, STALL_B, rb, cb, ob, sb);
    chk({name, ".ndone_a"}, done_n[0] - base_a, 1);
    chk({name, ".ndone_b"}, done_n[1] - base_b, 1);
    chk({name, ".done_at_a"}, done_at[0] - s, ra - s);
    chk({name, ".done_at_b"}, done_at[1] - s, rb - s);
    chk({name, ".count_a"}, count_a, ca);
    chk({name, ".count_b"}, count_b, cb);
    chk({name, ".ovf_a"}, ovf_a, oa);
    chk({name, ".ovf_b"}, ovf_b, ob);
    chk({name, ".stall_a"}, stall_a, sa);
    chk({name, ".stall_b"}, stall_b, sb);
    chk({name, ".cv_a"}, cv_a, 1);
    chk({name, ".cv_b"}, cv_b, 1);
    chk({name, ".idle_busy_a"}, busy_a, 0);
    chk({name, ".idle_held_a"}, rie_a, 1);
  endtask

  task automatic abort_run(input int gate);
    int s, base_a, base_b;
    @(negedge clk);
    cfg_gate = 16'(gate);
    start    = 1'b1;
    s        = cyc + 1;
    base_a   = done_n[0];
    base_b   = done_n[1];
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + INIT_C + SETTLE_C + 10) @(negedge clk);
    chk("abort.busy_before", busy_a, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.busy_a", busy_a, 0);
    chk("abort.busy_b", busy_b, 0);
    chk("abort.held_a", rie_a, 1);
    chk("abort.cv_a", cv_a, 0);
    chk("abort.count_a", count_a, 0);
    while (cyc < s + INIT_C + SETTLE_C + gate + 5) @(negedge clk);
    chk("abort.nodone_a", done_n[0] - base_a, 0);
    chk("abort.nodone_b", done_n[1] - base_b, 0);
  endtask

  initial begin
    int base_a;
    done_n  = '{0, 0};
    done_at = '{0, 0};
    repeat (2) @(negedge clk);
    chk("rst.ring_init_en", rie_a, 1);
    chk("rst.busy", busy_a, 0);
    chk("rst.done", done_a, 0);
    chk("rst.count", count_a, 0);
    chk("rst.count_valid", cv_a, 0);
    chk("rst.overflow", ovf_a, 0);
    chk("rst.stall", stall_a, 0);
    chk("rst.busy_b", busy_b, 0);
    chk("rst.init_val", riv_a, 30'h0000_7FFF);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    tmode = 1; tper = 4;
    run_meas("gate100_p4", 100, 1'b0);
    tper = 2;
    run_meas("gate0_p2", 0, 1'b0);
    run_meas("gate100_p2", 100, 1'b0);
    tper = 4;
    run_meas("midstart", 100, 1'b1);

    // start and abort together in IDLE: abort wins, previous results stay valid
    @(negedge clk);
    base_a = done_n[0];
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("startabort.busy", busy_a, 0);
    chk("startabort.held", rie_a, 1);
    chk("startabort.cv", cv_a, 1);
    repeat (10) @(negedge clk);
    chk("startabort.nodone", done_n[0] - base_a, 0);

    abort_run(100);

    tmode = 0;
    run_meas("const_tap", 100, 1'b0);

    for (int i = 0; i < 10; i++) begin
      tmode = ($urandom_range(0, 1) != 0) ? 2 : 1;
      tper  = $urandom_range(1, 7);
      tprob = $urandom_range(0, 60);
      run_meas("random", $urandom_range(0, 300), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
